// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit: one bit per clock, shift-add multiply
// and restoring divide sharing one 2*DATA_WIDTH accumulator.
module muldiv_sequencer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter logic [3:0]  MUL_CODE   = 4'b0001,
    parameter logic [3:0]  DIV_CODE   = 4'b0010
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            func_code,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result_lo,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic                  exc_div0
);
    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             exc_div0_q, exc_div0_d;
    logic [W-1:0]     result_lo_q, result_lo_d;
    logic [W-1:0]     result_hi_q, result_hi_d;

    logic             is_mul, is_div, accept, div0;
    logic [W:0]       mul_sum, div_shift, div_diff;
    logic [2*W-1:0]   mul_next, div_next;

    assign is_mul = (func_code == MUL_CODE);
    assign is_div = (func_code == DIV_CODE);
    assign accept = start && (is_mul || is_div) && !flush
                    && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign div0   = accept && !is_mul && (op_b == '0);

    // One iteration of each algorithm; acc holds {hi, lo} = {partial, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q & {W{acc_q[0]}}};
        mul_next  = {mul_sum, acc_q[W-1:1]};
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[W]) begin
            div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            exc_div0_q  <= 1'b0;
            result_lo_q <= '0;
            result_hi_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opnd_q      <= opnd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            exc_div0_q  <= exc_div0_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
        end
    end

    // Next state, iteration counter and datapath registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                if (accept && !div0) begin
                    if (is_mul) begin
                        state_d = S_MUL;
                        acc_d   = {W'(0), op_b};
                        opnd_d  = op_a;
                    end else begin
                        state_d = S_DIV;
                        acc_d   = {W'(0), op_a};
                        opnd_d  = op_b;
                    end
                end
            end
            S_MUL, S_DIV: begin
                acc_d = (state_q == S_MUL) ? mul_next : div_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered strobes/results follow the next state; stall is the only combinational output
    always_comb begin
        busy_d      = (state_d == S_MUL) || (state_d == S_DIV);
        done_d      = (state_d == S_DONE);
        exc_div0_d  = div0;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;
        if (state_d == S_DONE) begin
            if (state_q == S_MUL) begin
                {result_hi_d, result_lo_d} = mul_next;
            end else begin
                {result_hi_d, result_lo_d} = div_next;
            end
        end
        stall = rst_n && (busy_q || (accept && !div0));
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign exc_div0  = exc_div0_q;
    assign result_lo = result_lo_q;
    assign result_hi = result_hi_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: vector table plus random ops through a scoreboard,
// then hand sequences for back-to-back, flush, ignored starts and mid-op reset.
module tb_muldiv_sequencer;
    localparam int unsigned W = 16;
    localparam logic [3:0] MUL = 4'b0001;
    localparam logic [3:0] DIV = 4'b0010;
    localparam logic [3:0] ADD = 4'b1111;

    logic         clk = 1'b0;
    logic         rst_n, start, flush;
    logic [3:0]   func_code;
    logic [W-1:0] op_a, op_b, result_lo, result_hi;
    logic         busy, stall, done, exc_div0;

    typedef struct {
        logic [3:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         div0;
    } vec_t;

    vec_t         sb[$];
    vec_t         tbl[10];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_lo, last_hi;

    muldiv_sequencer #(.DATA_WIDTH(W), .MUL_CODE(MUL), .DIV_CODE(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func_code(func_code),
        .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy), .stall(stall),
        .done(done), .result_lo(result_lo), .result_hi(result_hi), .exc_div0(exc_div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present an op for one edge; operands are scrambled right after to show they are latched
    task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input vec_t e);
        @(negedge clk);
        start = 1'b1; func_code = f; op_a = a; op_b = b;
        #1;
        chk("stall_on_accept", 32'(stall), 32'(!(f == DIV && b == '0)));
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; func_code = ADD; op_a = W'($urandom); op_b = W'($urandom);
    endtask

    task automatic wait_result();
        int   edges    = 0;
        int   busy_cyc = 0;
        vec_t e;
        while (!done && !exc_div0 && edges < 40) begin
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            edges++;
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow actual=empty required=entry");
            return;
        end
        e = sb.pop_front();
        chk("latency", 32'(edges), e.div0 ? 32'd0 : 32'd16);
        chk("exc_div0", 32'(exc_div0), 32'(e.div0));
        chk("done", 32'(done), 32'(!e.div0));
        chk("busy_cycles", 32'(busy_cyc), e.div0 ? 32'd0 : 32'd16);
        chk("result_lo", 32'(result_lo), 32'(e.lo));
        chk("result_hi", 32'(result_hi), 32'(e.hi));
        last_lo = e.lo;
        last_hi = e.hi;
    endtask

    task automatic check_quiet(input string name, input int n);
        int seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done || exc_div0 || busy) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        vec_t        e;
        logic [31:0] p;

        rst_n = 1'b0; start = 1'b1; func_code = MUL; op_a = 16'd3; op_b = 16'd5; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_exc", 32'(exc_div0), 32'd0);
        chk("rst_lo", 32'(result_lo), 32'd0);
        chk("rst_hi", 32'(result_hi), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_lo = '0; last_hi = '0;

        tbl[0] = '{MUL, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0};
        tbl[1] = '{MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0};
        tbl[2] = '{DIV, 16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0};
        tbl[3] = '{DIV, 16'h0005, 16'h0000, 16'h000E, 16'h0002, 1'b1};
        tbl[4] = '{MUL, 16'h0000, 16'hABCD, 16'h0000, 16'h0000, 1'b0};
        tbl[5] = '{DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
        tbl[6] = '{DIV, 16'h1234, 16'h1234, 16'h0001, 16'h0000, 1'b0};
        tbl[7] = '{MUL, 16'h8000, 16'h0002, 16'h0000, 16'h0001, 1'b0};
        tbl[8] = '{DIV, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 1'b1};
        tbl[9] = '{DIV, 16'h0003, 16'h0010, 16'h0000, 16'h0003, 1'b0};

        for (int i = 0; i < 10; i++) begin
            issue(tbl[i].f, tbl[i].a, tbl[i].b, 1'b1, tbl[i]);
            wait_result();
            @(posedge clk);
            #1;
            chk("idle_after", 32'({done, busy, exc_div0}), 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            e.f = ($urandom_range(0, 1) == 0) ? MUL : DIV;
            e.a = W'($urandom);
            e.b = (i == 3) ? 16'h0000 : W'($urandom);
            e.div0 = 1'b0;
            if (e.f == MUL) begin
                p = 32'(e.a) * 32'(e.b);
                e.lo = p[15:0]; e.hi = p[31:16];
            end else if (e.b == '0) begin
                e.div0 = 1'b1; e.lo = last_lo; e.hi = last_hi;
            end else begin
                e.lo = e.a / e.b; e.hi = e.a % e.b;
            end
            issue(e.f, e.a, e.b, 1'b1, e);
            wait_result();
            @(posedge clk);
            #1;
        end

        // Back-to-back: new divide accepted in the DONE cycle
        e = '{DIV, 16'd100, 16'd7, 16'h000E, 16'h0002, 1'b0};
        issue(e.f, e.a, e.b, 1'b1, e);
        wait_result();
        e = '{DIV, 16'd7, 16'd100, 16'h0000, 16'h0007, 1'b0};
        start = 1'b1; func_code = DIV; op_a = 16'd7; op_b = 16'd100;
        sb.push_back(e);
        #1;
        chk("stall_in_done", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0; op_a = W'($urandom); op_b = W'($urandom);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done_low", 32'(done), 32'd0);
        wait_result();
        @(posedge clk);
        #1;

        // Flush mid-multiply, with an ignored start while busy
        issue(MUL, 16'h00FF, 16'h0101, 1'b0, e);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; func_code = DIV; op_a = 16'd9; op_b = 16'd3;
        #1;
        chk("stall_while_busy", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_start_ignored", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        check_quiet("flush_quiet", 20);
        chk("flush_lo_kept", 32'(result_lo), 32'(last_lo));
        chk("flush_hi_kept", 32'(result_hi), 32'(last_hi));

        // Flush beats start in the same cycle
        @(negedge clk);
        flush = 1'b1; start = 1'b1; func_code = MUL; op_a = 16'd2; op_b = 16'd2;
        #1;
        chk("flush_start_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; start = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);

        // Unsupported func_code is ignored
        @(negedge clk);
        start = 1'b1; func_code = ADD;
        #1;
        chk("add_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("add_busy", 32'(busy), 32'd0);
        chk("add_lo_kept", 32'(result_lo), 32'(last_lo));

        // Reset during a divide
        issue(DIV, 16'hBEEF, 16'h0013, 1'b0, e);
        repeat (8) @(posedge clk);
        @(negedge clk);
        start = 1'b1; func_code = MUL; rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_exc", 32'(exc_div0), 32'd0);
        chk("mid_rst_lo", 32'(result_lo), 32'd0);
        chk("mid_rst_hi", 32'(result_hi), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_quiet("post_rst_quiet", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, operand/result width.
REQ-002 Parameter: MUL_CODE, default 4'b0001, func_code selecting multiply.
REQ-003 Parameter: DIV_CODE, default 4'b0010, func_code selecting divide.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request from control when an ALU-type op is issued.
REQ-007 func_code  input  4  operation select; only MUL_CODE/DIV_CODE are acted on.
REQ-008 op_a  input  DATA_WIDTH  multiplicand / dividend.
REQ-009 op_b  input  DATA_WIDTH  multiplier / divisor.
REQ-010 flush  input  1  synchronous abort from exception/halt logic.
REQ-011 busy  output  1  high while iterating (states MUL, DIV).
REQ-012 stall  output  1  combinational pipeline hold request.
REQ-013 done  output  1  one-cycle result-valid strobe.
REQ-014 result_lo  output  DATA_WIDTH  product low half / quotient, destined for rd.
REQ-015 result_hi  output  DATA_WIDTH  product high half / remainder, destined for R0.
REQ-016 exc_div0  output  1  one-cycle divide-by-zero exception to control.

Function
REQ-017 States: IDLE, MUL, DIV, DONE; registered state, registered 5-bit iteration counter.
REQ-018 Accept: start=1 with func_code in {MUL_CODE, DIV_CODE}, in state IDLE or DONE, flush=0; operands latched on accepting edge.
REQ-019 start with any other func_code, or while in MUL/DIV, is ignored; no state change.
REQ-020 Accepted MUL -> state MUL, counter=0; accepted DIV with op_b!=0 -> state DIV, counter=0.
REQ-021 Accepted DIV with op_b==0 -> exc_div0=1 for the cycle after the accepting edge, state IDLE, result_lo/result_hi unchanged, done stays 0.
REQ-022 MUL: unsigned shift-add, one multiplier bit per edge, LSB first; 2*DATA_WIDTH-bit accumulator.
REQ-023 DIV: unsigned restoring division, one quotient bit per edge, MSB first.
REQ-024 Counter increments each edge in MUL/DIV; edge on which counter reaches DATA_WIDTH-1 -> state DONE.
REQ-025 Latency: done=1 exactly DATA_WIDTH edges after the accepting edge, for one cycle (state DONE).
REQ-026 DONE with no new accept -> IDLE on next edge; DONE with accept -> MUL/DIV directly (back-to-back, no idle bubble).
REQ-027 result_lo/result_hi update only on entry to DONE; hold value until next entry to DONE or reset.
REQ-028 MUL result: {result_hi,result_lo} = op_a*op_b, full 2*DATA_WIDTH bits, no truncation.
REQ-029 DIV result: result_lo = op_a/op_b, result_hi = op_a%op_b.
REQ-030 busy = (state==MUL)|(state==DIV).
REQ-031 stall = busy | (accept condition of REQ-018 true in current cycle and not divide-by-zero).
REQ-032 flush=1 in MUL/DIV/DONE -> IDLE next edge; done and exc_div0 not asserted; results unchanged.
REQ-033 flush and start same cycle: flush wins; start ignored.
REQ-034 Operand inputs may change after accept without affecting the running operation.

Reset
REQ-035 rst_n=0 asynchronously forces state IDLE, counter 0, busy 0, done 0, exc_div0 0, result_lo 0, result_hi 0, internal accumulators 0.
REQ-036 Reset asserted mid-operation abandons it; no done or exc_div0 after rst_n deasserts.
REQ-037 stall=0 while rst_n=0 regardless of start.

Verification
REQ-038 MUL op_a=0x1234, op_b=0x0010 -> done 16 edges after accept; result_hi=0x0001, result_lo=0x2340; busy high 16 cycles.
REQ-039 MUL op_a=0xFFFF, op_b=0xFFFF -> result_hi=0xFFFE, result_lo=0x0001.
REQ-040 DIV op_a=100, op_b=7 -> result_lo=0x000E, result_hi=0x0002; then start held in DONE with DIV 7/100 -> back-to-back, result_lo=0, result_hi=7.
REQ-041 DIV op_b=0 -> exc_div0 one cycle, done never high, busy never high, prior results retained.
REQ-042 MUL accepted, flush at iteration 5 -> IDLE next edge, no done, results unchanged; start with func_code=ADD (4'b1111) -> ignored, stall=0.
REQ-043 rst_n pulsed low at iteration 8 of DIV -> all outputs 0 immediately, no done afterward.
